// File: rtl/eth_rx_mac_pkg.sv
// eth_rx_mac_pkg: shared states, framing bytes, CRC constants and byte-wise CRC step
package eth_rx_mac_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, STATUS} state_t;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam int ERR_RUNT = 0;
  localparam int ERR_GIANT = 1;
  localparam int ERR_ALIGN = 2;
  localparam int ERR_RXER = 3;
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] x;
    x = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) x = x[0] ? (x >> 1) ^ CRC_POLY : x >> 1;
    return x;
  endfunction
endpackage

// File: rtl/eth_rx_mac_if.sv
// eth_rx_mac_if: PHY receive pins in, byte stream and frame status out
interface eth_rx_mac_if #(parameter int PHY_W = 2);
  logic [PHY_W-1:0] phy_rxd;
  logic phy_rxdv;
  logic phy_rxer;
  logic [7:0] d;
  logic dv;
  logic sof;
  logic eof;
  logic good;
  logic [10:0] len;
  logic [3:0] err;
  modport master (output phy_rxd, phy_rxdv, phy_rxer, input d, dv, sof, eof, good, len, err);
  modport slave (input phy_rxd, phy_rxdv, phy_rxer, output d, dv, sof, eof, good, len, err);
endinterface

// File: rtl/eth_rx_mac_crc32.sv
// eth_rx_mac_crc32: frame CRC-32 register advanced one byte per enable
module eth_rx_mac_crc32
  import eth_rx_mac_pkg::*;
(
  input  logic        c,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  b,
  output logic [31:0] crc
);
  // Preset at SFD, fold in each completed byte
  always_ff @(posedge c) crc <= rst ? '0 : init ? CRC_INIT : en ? crc32_d8(crc, b) : crc;
endmodule

// File: rtl/eth_rx_mac.sv
// eth_rx_mac: MII/RMII receive front end producing bytes, FCS check and frame status
module eth_rx_mac
  import eth_rx_mac_pkg::*;
#(
  parameter int PHY_W = 2,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522,
  parameter int STRIP = 1
) (
  input logic c,
  input logic rst,
  eth_rx_mac_if.slave m
);
  localparam logic [1:0] LAST = 2'(8 / PHY_W - 1);
  localparam logic [10:0] OFF = STRIP != 0 ? 11'd4 : 11'd0;
  localparam logic [10:0] LO = 11'(MIN_LEN);
  localparam logic [10:0] HI = 11'(MAX_LEN);
  state_t st, st_n;
  logic [PHY_W-1:0] rxd1, rxd2;
  logic [1:0] dv_s, er_s;
  logic dv1, dv2, rxer, first;
  logic [7:0] sr;
  logic [3:0][7:0] dl;
  logic [1:0] beat;
  logic [10:0] cnt;
  logic [31:0] crc;
  logic [3:0] err_n;
  logic v, sfd, byte_ok, fin, emit;

  eth_rx_mac_crc32 u_crc (.c(c), .rst(rst), .init(sfd), .en(byte_ok), .b(sr), .crc(crc));

  // Beat in sr is valid if its dv was high or it sits in a one-cycle CRS_DV gap
  always_comb begin
    v = dv1 | (dv2 & dv_s[1]);
    sfd = st == PREAMBLE & dv1 & sr == SFD_BYTE;
    byte_ok = st == PAYLOAD & v & beat == LAST;
    fin = st == PAYLOAD & ~dv_s[1] & ~dv1;
    emit = byte_ok & cnt >= OFF & cnt < HI + OFF;
    err_n = {rxer | er_s[1], beat != 2'd0, cnt > HI, cnt < LO};
    st_n = st == IDLE ? (dv1 & sr == PRE_BYTE ? PREAMBLE : IDLE)
         : st == PREAMBLE ? (dv1 & sr == PRE_BYTE ? PREAMBLE : sfd ? PAYLOAD : IDLE)
         : st == PAYLOAD ? (fin ? STATUS : PAYLOAD) : IDLE;
  end

  // State register
  always_ff @(posedge c) st <= rst ? IDLE : st_n;

  // Two-flop input synchroniser, LSB-first shift register and dv history
  always_ff @(posedge c) begin
    if (rst) begin
      rxd1 <= '0;
      rxd2 <= '0;
      dv_s <= '0;
      er_s <= '0;
      dv1 <= 1'b0;
      dv2 <= 1'b0;
      sr <= '0;
    end else begin
      rxd1 <= m.phy_rxd;
      rxd2 <= rxd1;
      dv_s <= {dv_s[0], m.phy_rxdv};
      er_s <= {er_s[0], m.phy_rxer};
      dv1 <= dv_s[1];
      dv2 <= dv1;
      sr <= {rxd2, sr[7:PHY_W]};
    end
  end

  // Byte assembly, FCS-hiding delay line, output strobes and end-of-frame status
  always_ff @(posedge c) begin
    if (rst) begin
      beat <= '0;
      cnt <= '0;
      dl <= '0;
      rxer <= 1'b0;
      first <= 1'b0;
      m.d <= '0;
      m.dv <= 1'b0;
      m.sof <= 1'b0;
      m.eof <= 1'b0;
      m.good <= 1'b0;
      m.len <= '0;
      m.err <= '0;
    end else begin
      beat <= sfd ? 2'd0 : st == PAYLOAD & v ? (beat == LAST ? 2'd0 : beat + 2'd1) : beat;
      cnt <= sfd ? 11'd0 : byte_ok & cnt != 11'h7FF ? cnt + 11'd1 : cnt;
      dl <= byte_ok ? {dl[2:0], sr} : dl;
      rxer <= sfd ? 1'b0 : rxer | (st == PAYLOAD & er_s[1]);
      first <= sfd | (first & ~emit);
      m.d <= emit ? (STRIP != 0 ? dl[3] : sr) : m.d;
      m.dv <= emit;
      m.sof <= emit & first;
      m.eof <= fin;
      m.good <= fin ? crc == CRC_RESIDUE & err_n == 4'd0 : m.good;
      m.len <= fin ? cnt : m.len;
      m.err <= fin ? err_n : m.err;
    end
  end
endmodule

// File: tb/tb_eth_rx_mac.sv
// tb_eth_rx_mac: directed frame tests for the RMII and MII receive paths
module tb_eth_rx_mac;
  logic c = 1'b0;
  logic rst = 1'b1;
  logic [7:0] fr [0:2047];
  int flen = 0;
  int nchk = 0, nfail = 0;
  int dvc2 = 0, sofc2 = 0, eofc2 = 0, goodc2 = 0, bad2 = 0, i2 = 0;
  int dvc4 = 0, sofc4 = 0, eofc4 = 0, goodc4 = 0, bad4 = 0, i4 = 0;

  eth_rx_mac_if #(.PHY_W(2)) if2 ();
  eth_rx_mac_if #(.PHY_W(4)) if4 ();
  eth_rx_mac #(.PHY_W(2)) u2 (.c(c), .rst(rst), .m(if2.slave));
  eth_rx_mac #(.PHY_W(4)) u4 (.c(c), .rst(rst), .m(if4.slave));

  always #5 c = ~c;

  always @(negedge c) begin
    if (if2.dv) begin
      if (if2.sof) i2 = 0;
      if (i2 >= flen) bad2++;
      else if (if2.d !== fr[i2]) bad2++;
      i2++;
      dvc2++;
      sofc2 += int'(if2.sof);
    end else if (if2.sof) bad2++;
    if (if2.eof) begin
      eofc2++;
      goodc2 += int'(if2.good);
      if (if2.dv) bad2++;
    end
    if (if4.dv) begin
      if (if4.sof) i4 = 0;
      if (i4 >= flen) bad4++;
      else if (if4.d !== fr[i4]) bad4++;
      i4++;
      dvc4++;
      sofc4 += int'(if4.sof);
    end else if (if4.sof) bad4++;
    if (if4.eof) begin
      eofc4++;
      goodc4 += int'(if4.good);
      if (if4.dv) bad4++;
    end
  end

  task automatic drive(input int w, input logic [3:0] d, input logic dv, input logic er);
    @(posedge c);
    #1;
    if (w == 2) begin
      if2.phy_rxd = d[1:0];
      if2.phy_rxdv = dv;
      if2.phy_rxer = er;
    end else begin
      if4.phy_rxd = d;
      if4.phy_rxdv = dv;
      if4.phy_rxer = er;
    end
  endtask

  task automatic build(input int np, input int seed);
    logic [31:0] crc;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < np; i++) begin
      fr[i] = 8'((i * 37 + seed * 11) ^ (i >> 3));
      crc = crc ^ {24'd0, fr[i]};
      for (int k = 0; k < 8; k++) crc = crc[0] ? (crc >> 1) ^ 32'hEDB88320 : crc >> 1;
    end
    crc = ~crc;
    for (int k = 0; k < 4; k++) fr[np + k] = crc[8*k +: 8];
    flen = np + 4;
  endtask

  task automatic send(input int w, input int extra, input int tog, input int er_at, input int cut);
    int nb, tot;
    logic [7:0] b, s;
    nb = 8 / w;
    tot = (8 + flen) * nb + extra;
    for (int j = 0; j < tot && j != cut; j++) begin
      b = j / nb < 7 ? 8'h55 : j / nb == 7 ? 8'hD5 : j / nb < 8 + flen ? fr[j / nb - 8] : 8'h00;
      s = b >> ((j % nb) * w);
      drive(w, s[3:0], !(tog != 0 && j >= tot - 8 && (tot - 1 - j) % 2 == 1), j == er_at);
    end
    if (cut < 0) drive(w, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_eof(input int w, input int target, input string name);
    for (int k = 0; k < 400 && (w == 2 ? eofc2 : eofc4) < target; k++) @(posedge c);
    repeat (4) @(posedge c);
    @(negedge c);
    nchk++;
    if ((w == 2 ? eofc2 : eofc4) != target) begin
      nfail++;
      $display("FAIL %s eof_count: got %0d, required %0d", name, w == 2 ? eofc2 : eofc4, target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge c);
    @(negedge c);
    nchk++;
    if ({if2.d, if2.dv, if2.sof, if2.eof, if2.good, if2.len, if2.err} !== 27'd0) begin
      nfail++;
      $display("FAIL reset_rmii: outputs %h, required 0", {if2.d, if2.dv, if2.sof, if2.eof, if2.good, if2.len, if2.err});
    end
    nchk++;
    if ({if4.d, if4.dv, if4.sof, if4.eof, if4.good, if4.len, if4.err} !== 27'd0) begin
      nfail++;
      $display("FAIL reset_mii: outputs %h, required 0", {if4.d, if4.dv, if4.sof, if4.eof, if4.good, if4.len, if4.err});
    end
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    int d0, s0, b0, e0;
    build(60, 1);
    d0 = dvc2; s0 = sofc2; b0 = bad2; e0 = eofc2;
    send(2, 0, 0, -1, -1);
    wait_eof(2, e0 + 1, "good_frame");
    nchk++;
    if (dvc2 - d0 != 60) begin nfail++; $display("FAIL good_frame dv_count: got %0d, required 60", dvc2 - d0); end
    nchk++;
    if (sofc2 - s0 != 1) begin nfail++; $display("FAIL good_frame sof_count: got %0d, required 1", sofc2 - s0); end
    nchk++;
    if (bad2 - b0 != 0) begin nfail++; $display("FAIL good_frame data: %0d bad bytes/strobes, required 0", bad2 - b0); end
    nchk++;
    if ({if2.good, if2.len, if2.err} !== {1'b1, 11'd64, 4'b0000}) begin
      nfail++;
      $display("FAIL good_frame status: good=%b len=%0d err=%b, required good=1 len=64 err=0000", if2.good, if2.len, if2.err);
    end
  endtask

  task automatic test_bad_fcs();
    int b0, e0;
    build(60, 1);
    fr[10] = fr[10] ^ 8'h04;
    b0 = bad2; e0 = eofc2;
    send(2, 0, 0, -1, -1);
    wait_eof(2, e0 + 1, "bad_fcs");
    nchk++;
    if (bad2 - b0 != 0) begin nfail++; $display("FAIL bad_fcs data: %0d bad bytes/strobes, required 0", bad2 - b0); end
    nchk++;
    if ({if2.good, if2.len, if2.err} !== {1'b0, 11'd64, 4'b0000}) begin
      nfail++;
      $display("FAIL bad_fcs status: good=%b len=%0d err=%b, required good=0 len=64 err=0000", if2.good, if2.len, if2.err);
    end
  endtask

  task automatic test_giant();
    int d0, b0, e0;
    build(1596, 3);
    d0 = dvc4; b0 = bad4; e0 = eofc4;
    send(4, 0, 0, -1, -1);
    wait_eof(4, e0 + 1, "giant");
    nchk++;
    if (dvc4 - d0 != 1522) begin nfail++; $display("FAIL giant dv_count: got %0d, required 1522", dvc4 - d0); end
    nchk++;
    if (bad4 - b0 != 0) begin nfail++; $display("FAIL giant data: %0d bad bytes/strobes, required 0", bad4 - b0); end
    nchk++;
    if ({if4.good, if4.len, if4.err} !== {1'b0, 11'd1600, 4'b0010}) begin
      nfail++;
      $display("FAIL giant status: good=%b len=%0d err=%b, required good=0 len=1600 err=0010", if4.good, if4.len, if4.err);
    end
  endtask

  task automatic test_runt();
    int d0, e0;
    build(16, 5);
    d0 = dvc2; e0 = eofc2;
    send(2, 0, 0, -1, -1);
    wait_eof(2, e0 + 1, "runt");
    nchk++;
    if (dvc2 - d0 != 16) begin nfail++; $display("FAIL runt dv_count: got %0d, required 16", dvc2 - d0); end
    nchk++;
    if ({if2.good, if2.len, if2.err} !== {1'b0, 11'd20, 4'b0001}) begin
      nfail++;
      $display("FAIL runt status: good=%b len=%0d err=%b, required good=0 len=20 err=0001", if2.good, if2.len, if2.err);
    end
  endtask

  task automatic test_align();
    int e0;
    build(60, 7);
    e0 = eofc2;
    send(2, 1, 0, -1, -1);
    wait_eof(2, e0 + 1, "align");
    nchk++;
    if ({if2.good, if2.len, if2.err} !== {1'b0, 11'd64, 4'b0100}) begin
      nfail++;
      $display("FAIL align status: good=%b len=%0d err=%b, required good=0 len=64 err=0100", if2.good, if2.len, if2.err);
    end
  endtask

  task automatic test_rxer();
    int e0;
    build(60, 9);
    e0 = eofc2;
    send(2, 0, 0, 152, -1);
    wait_eof(2, e0 + 1, "rxer");
    nchk++;
    if ({if2.good, if2.len, if2.err} !== {1'b0, 11'd64, 4'b1000}) begin
      nfail++;
      $display("FAIL rxer status: good=%b len=%0d err=%b, required good=0 len=64 err=1000", if2.good, if2.len, if2.err);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    build(60, 11);
    e0 = eofc2;
    send(2, 0, 0, -1, 160);
    rst = 1'b1;
    if2.phy_rxdv = 1'b0;
    repeat (2) @(posedge c);
    @(negedge c);
    nchk++;
    if ({if2.d, if2.dv, if2.sof, if2.eof, if2.good, if2.len, if2.err} !== 27'd0) begin
      nfail++;
      $display("FAIL reset_mid outputs: %h, required 0", {if2.d, if2.dv, if2.sof, if2.eof, if2.good, if2.len, if2.err});
    end
    rst = 1'b0;
    repeat (40) @(posedge c);
    @(negedge c);
    nchk++;
    if (eofc2 != e0) begin nfail++; $display("FAIL reset_mid eof_count: got %0d, required %0d", eofc2, e0); end
    nchk++;
    if ({if2.d, if2.dv, if2.sof, if2.eof, if2.good, if2.len, if2.err} !== 27'd0) begin
      nfail++;
      $display("FAIL reset_mid idle_outputs: %h, required 0", {if2.d, if2.dv, if2.sof, if2.eof, if2.good, if2.len, if2.err});
    end
  endtask

  task automatic test_back_to_back();
    int d0, b0, e0, g0;
    build(60, 13);
    d0 = dvc2; b0 = bad2; e0 = eofc2; g0 = goodc2;
    send(2, 0, 1, -1, -1);
    repeat (47) drive(2, 4'd0, 1'b0, 1'b0);
    send(2, 0, 0, -1, -1);
    wait_eof(2, e0 + 2, "back_to_back");
    nchk++;
    if (goodc2 - g0 != 2) begin nfail++; $display("FAIL back_to_back good_count: got %0d, required 2", goodc2 - g0); end
    nchk++;
    if (dvc2 - d0 != 120) begin nfail++; $display("FAIL back_to_back dv_count: got %0d, required 120", dvc2 - d0); end
    nchk++;
    if (bad2 - b0 != 0) begin nfail++; $display("FAIL back_to_back data: %0d bad bytes/strobes, required 0", bad2 - b0); end
    nchk++;
    if ({if2.len, if2.err} !== {11'd64, 4'b0000}) begin
      nfail++;
      $display("FAIL back_to_back status: len=%0d err=%b, required len=64 err=0000", if2.len, if2.err);
    end
  endtask

  initial begin
    if2.phy_rxd = '0;
    if2.phy_rxdv = 1'b0;
    if2.phy_rxer = 1'b0;
    if4.phy_rxd = '0;
    if4.phy_rxdv = 1'b0;
    if4.phy_rxer = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_giant();
    test_runt();
    test_align();
    test_rxer();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
